// File: rtl/gru_gate_mac_unit_pkg.sv
// Shared GRU gate types and fixed-point helpers.
// GRU_GATE_SAT_EN selects saturating narrow(); otherwise narrow() wraps.
package gru_pkg;

  typedef enum logic {
    SIGMOID    = 1'b0,
    TANH_RESET = 1'b1
  } gate_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC_X,
    S_MAC_H,
    S_GATE,
    S_SUM,
    S_ACT,
    S_HOLD
  } gate_state_t;

  typedef logic signed [63:0] wide_t;

  function automatic wide_t max_of(int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  function automatic wide_t min_of(int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

  function automatic logic clip_hit(wide_t v, int dw);
`ifdef GRU_GATE_SAT_EN
    return (v > max_of(dw)) || (v < min_of(dw));
`else
    return 1'b0;
`endif
  endfunction

  function automatic wide_t narrow(wide_t v, int dw);
`ifdef GRU_GATE_SAT_EN
    if (v > max_of(dw)) return max_of(dw);
    if (v < min_of(dw)) return min_of(dw);
    return v;
`else
    return (v <<< (64 - dw)) >>> (64 - dw);
`endif
  endfunction

  function automatic wide_t tanh_pwl(wide_t s, int fb);
    wide_t one;
    one = 64'sd1 <<< fb;
    if (s < -(one <<< 1)) return -one;
    if (s > (one <<< 1)) return one;
    return s >>> 1;
  endfunction

  function automatic wide_t sigmoid_hard(wide_t s, int fb);
    wide_t one, t;
    one = 64'sd1 <<< fb;
    t = (one >>> 1) + (s >>> 2);
    if (t < 0) return '0;
    if (t > one) return one;
    return t;
  endfunction

endpackage

// File: rtl/gru_gate_mac_unit_if.sv
// Start, operand and result handshakes of the GRU gate element.
// master = scheduler side, slave = gate unit.
interface gru_gate_mac_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4
);
  logic                          start_valid;
  logic                          start_ready;
  logic                          mode;
  logic signed [DATA_WIDTH-1:0]  r_gate;
  logic signed [DATA_WIDTH-1:0]  b_i;
  logic signed [DATA_WIDTH-1:0]  b_h;
  logic                          op_valid;
  logic                          op_ready;
  logic [LANES*DATA_WIDTH-1:0]   op_w;
  logic [LANES*DATA_WIDTH-1:0]   op_a;
  logic                          op_last;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [DATA_WIDTH-1:0]  out_data;
  logic                          out_sat;
  logic                          out_err;

  modport master (
    output start_valid, mode, r_gate, b_i, b_h,
    output op_valid, op_w, op_a, op_last, out_ready,
    input  start_ready, op_ready,
    input  out_valid, out_data, out_sat, out_err
  );

  modport slave (
    input  start_valid, mode, r_gate, b_i, b_h,
    input  op_valid, op_w, op_a, op_last, out_ready,
    output start_ready, op_ready,
    output out_valid, out_data, out_sat, out_err
  );
endinterface

// File: rtl/gru_gate_mac_unit_lane_dot.sv
// gru_lane_dot: LANES-wide signed multiply and exact sum.
// Result is 2*DATA_WIDTH+$clog2(LANES) bits, never overflows.
module gru_lane_dot #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4
) (
  input  logic [LANES*DATA_WIDTH-1:0] w,
  input  logic [LANES*DATA_WIDTH-1:0] a,
  output logic signed [2*DATA_WIDTH+$clog2(LANES)-1:0] sum
);
  localparam int SW = 2*DATA_WIDTH + $clog2(LANES);

  logic signed [2*DATA_WIDTH-1:0] prod [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod[i] = $signed(w[i*DATA_WIDTH +: DATA_WIDTH])
              * $signed(a[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SW'(prod[i]);
    end
  end
endmodule

// File: rtl/gru_gate_mac_unit.sv
// Streaming GRU gate element: dual MAC, gate combine, hard activation.
// GRU_GATE_SAT_EN enables saturating narrowing and out_sat reporting.
module gru_gate_mac_unit
  import gru_pkg::*;
#(
  parameter int D          = 128,
  parameter int H          = 256,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(D+H)
) (
  input logic               clk,
  input logic               rst,
  gru_gate_mac_unit_if.slave bus
);
  localparam int NX = D / LANES;
  localparam int NT = (D + H) / LANES;
  localparam int BW = $clog2(NT + 1);
  localparam int DW = DATA_WIDTH;
  localparam logic [BW-1:0] LAST_X = BW'(NX - 1);
  localparam logic [BW-1:0] LAST_T = BW'(NT - 1);

  if ((D % LANES) != 0 || (H % LANES) != 0) begin : g_bad_lanes
    $error("D and H must be multiples of LANES");
  end

  gate_state_t state, nxt;
  gate_mode_t  mode_q;

  logic signed [DW-1:0]        r_q, bi_q, bh_q;
  logic signed [DW-1:0]        g_q, s_q, out_q;
  logic signed [ACC_WIDTH-1:0] acc_x, acc_h;
  logic [BW-1:0]               beat;
  logic                        sat_q, err_q;

  logic signed [2*DW+$clog2(LANES)-1:0] dot;

  gru_lane_dot #(
    .DATA_WIDTH (DW),
    .LANES      (LANES)
  ) u_dot (
    .w   (bus.op_w),
    .a   (bus.op_a),
    .sum (dot)
  );

  wide_t ax, ah, hid_pre, hid, prod, g_n;
  wide_t sum_pre, s_n, act_n;
  logic  g_hit, s_hit;

  // GATE and SUM work from registered operands, one stage per state
  always_comb begin
    ax      = wide_t'(acc_x) >>> FRAC_BITS;
    ah      = wide_t'(acc_h) >>> FRAC_BITS;
    hid_pre = narrow(ah, DW) + wide_t'(bh_q);
    hid     = narrow(hid_pre, DW);
    prod    = (wide_t'(r_q) * hid) >>> FRAC_BITS;
    g_n     = (mode_q == TANH_RESET) ? narrow(prod, DW) : hid;
    g_hit   = clip_hit(ah, DW) | clip_hit(hid_pre, DW)
            | ((mode_q == TANH_RESET) & clip_hit(prod, DW));
    sum_pre = narrow(ax, DW) + wide_t'(bi_q) + wide_t'(g_q);
    s_n     = narrow(sum_pre, DW);
    s_hit   = clip_hit(ax, DW) | clip_hit(sum_pre, DW);
    act_n   = (mode_q == TANH_RESET) ? tanh_pwl(wide_t'(s_q), FRAC_BITS)
                                     : sigmoid_hard(wide_t'(s_q), FRAC_BITS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (bus.start_valid) nxt = S_MAC_X;
      S_MAC_X: if (bus.op_valid && beat == LAST_X) nxt = S_MAC_H;
      S_MAC_H: if (bus.op_valid && beat == LAST_T) nxt = S_GATE;
      S_GATE:  nxt = S_SUM;
      S_SUM:   nxt = S_ACT;
      S_ACT:   nxt = S_HOLD;
      S_HOLD:  if (bus.out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.start_ready = (state == S_IDLE) && !rst;
    bus.op_ready    = (state == S_MAC_X) || (state == S_MAC_H);
    bus.out_valid   = (state == S_HOLD);
    bus.out_data    = out_q;
    bus.out_sat     = sat_q;
    bus.out_err     = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= SIGMOID;
      r_q    <= '0;
      bi_q   <= '0;
      bh_q   <= '0;
      g_q    <= '0;
      s_q    <= '0;
      out_q  <= '0;
      acc_x  <= '0;
      acc_h  <= '0;
      beat   <= '0;
      sat_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          acc_x <= '0;
          acc_h <= '0;
          beat  <= '0;
          sat_q <= 1'b0;
          err_q <= 1'b0;
          if (bus.start_valid) begin
            mode_q <= gate_mode_t'(bus.mode);
            r_q    <= bus.r_gate;
            bi_q   <= bus.b_i;
            bh_q   <= bus.b_h;
          end
        end
        S_MAC_X, S_MAC_H: begin
          if (bus.op_valid) begin
            if (state == S_MAC_X) acc_x <= acc_x + ACC_WIDTH'(dot);
            else                  acc_h <= acc_h + ACC_WIDTH'(dot);
            beat <= beat + 1'b1;
            // op_last must coincide exactly with the final beat
            if (bus.op_last != (beat == LAST_T)) err_q <= 1'b1;
          end
        end
        S_GATE: begin
          g_q   <= DW'(g_n);
          sat_q <= sat_q | g_hit;
        end
        S_SUM: begin
          s_q   <= DW'(s_n);
          sat_q <= sat_q | s_hit;
        end
        S_ACT:   out_q <= DW'(act_n);
        S_HOLD:  ;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gru_gate_mac_unit.sv
// Directed bench for gru_gate_mac_unit (D=H=4, LANES=2, Q8.8).
// Expected out_sat follows GRU_GATE_SAT_EN.
module tb_gru_gate_mac_unit;
  localparam int DW = 16;
  localparam int LN = 2;
`ifdef GRU_GATE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;

  gru_gate_mac_unit_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

  gru_gate_mac_unit #(
    .D (4), .H (4), .DATA_WIDTH (DW), .FRAC_BITS (8), .LANES (LN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic md, input logic signed [15:0] r,
                          input logic signed [15:0] bi,
                          input logic signed [15:0] bh,
                          output int t0);
    int n;
    bus.mode = md; bus.r_gate = r; bus.b_i = bi; bus.b_h = bh;
    bus.start_valid = 1'b1;
    n = 0;
    while (!bus.start_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    bus.start_valid = 1'b0;
  endtask

  task automatic do_beat(input logic signed [15:0] w,
                         input logic signed [15:0] a,
                         input logic last, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    bus.op_w = {w, w}; bus.op_a = {a, a};
    bus.op_last = last; bus.op_valid = 1'b1;
    n = 0;
    while (!bus.op_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op_last = 1'b0;
  endtask

  task automatic wait_out(input int t0, output int lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    lat = bus.out_valid ? (cyc - t0 + 1) : -1;
  endtask

  task automatic finish_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_txn(input logic md, input logic signed [15:0] r,
                         input logic signed [15:0] wx,
                         input logic signed [15:0] xa,
                         input logic signed [15:0] wh,
                         input logic signed [15:0] ha,
                         input logic [3:0] lmask, input int gap,
                         output int lat);
    int t0;
    do_start(md, r, 16'sd0, 16'sd0, t0);
    do_beat(wx, xa, lmask[0], gap);
    do_beat(wx, xa, lmask[1], gap);
    do_beat(wh, ha, lmask[2], gap);
    do_beat(wh, ha, lmask[3], gap);
    wait_out(t0, lat);
  endtask

  initial begin
    int lat, hi;
    bus.start_valid = 0; bus.mode = 0; bus.r_gate = 0;
    bus.b_i = 0; bus.b_h = 0; bus.op_valid = 0;
    bus.op_w = '0; bus.op_a = '0; bus.op_last = 0; bus.out_ready = 0;

    repeat (2) @(negedge clk);
    chk("rst_start_ready", bus.start_ready, 0);
    chk("rst_op_ready", bus.op_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sat", bus.out_sat, 0);
    chk("rst_out_err", bus.out_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_start_ready", bus.start_ready, 1);

    // tanh: x=1.0, w=0.25 -> s=1.0 -> 0.5
    run_txn(1'b1, 16'sd256, 16'sd64, 16'sd256, 16'sd64, 16'sd0,
            4'b1000, 0, lat);
    chk("t1_lat", lat, 8);
    chk("t1_data", bus.out_data, 128);
    chk("t1_sat", bus.out_sat, 0);
    chk("t1_err", bus.out_err, 0);
    finish_out();

    run_txn(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
            4'b1000, 0, lat);
    chk("sig0_data", bus.out_data, 128);
    finish_out();

    run_txn(1'b0, 16'sd0, 16'sd256, 16'sd256, 16'sd0, 16'sd0,
            4'b1000, 0, lat);
    chk("sig4_data", bus.out_data, 256);
    chk("sig4_sat", bus.out_sat, 0);
    finish_out();

    // hidden term 3.0 masked by r_gate=0
    run_txn(1'b1, 16'sd0, 16'sd0, 16'sd0, 16'sd192, 16'sd256,
            4'b1000, 0, lat);
    chk("rmask_data", bus.out_data, 0);
    chk("rmask_err", bus.out_err, 0);
    finish_out();

    // sat: acc>>>8 = 0xFC0400 clamps to 32767; wrap keeps 0x0400
    run_txn(1'b0, 16'sd0, 16'sh7F00, 16'sh7F00, 16'sh7F00, 16'sh7F00,
            4'b1000, 0, lat);
    chk("big_data", bus.out_data, 256);
    chk("big_sat", bus.out_sat, 32'(SAT_EN));
    finish_out();

    run_txn(1'b1, 16'sd256, 16'sd64, 16'sd256, 16'sd64, 16'sd0,
            4'b1000, 1, lat);
    chk("bub_lat", lat, 12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, 128);
      chk("hold_start_ready", bus.start_ready, 0);
    end
    finish_out();
    chk("post_hs_valid", bus.out_valid, 0);
    chk("post_hs_start_ready", bus.start_ready, 1);

    run_txn(1'b1, 16'sd256, 16'sd64, 16'sd256, 16'sd64, 16'sd0,
            4'b1010, 0, lat);
    chk("last_err", bus.out_err, 1);
    chk("last_data", bus.out_data, 128);
    finish_out();

    begin
      int t0;
      do_start(1'b1, 16'sd256, 16'sd0, 16'sd0, t0);
      do_beat(16'sd64, 16'sd256, 1'b0, 0);
      do_beat(16'sd64, 16'sd256, 1'b0, 0);
      do_beat(16'sd64, 16'sd0, 1'b0, 0);
    end
    rst = 1'b1;
    #1;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_op_ready", bus.op_ready, 0);
    chk("mrst_start_ready", bus.start_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_release_ready", bus.start_ready, 1);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) hi++;
    end
    chk("mrst_no_output", hi, 0);

    run_txn(1'b1, 16'sd256, 16'sd64, 16'sd256, 16'sd64, 16'sd0,
            4'b1000, 0, lat);
    chk("after_rst_data", bus.out_data, 128);
    chk("after_rst_err", bus.out_err, 0);
    chk("after_rst_lat", lat, 8);
    finish_out();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/gru_gate_mac_unit.md
# gru_gate_mac_unit

Streaming, parametrised GRU gate element that computes one element of the reset, update or candidate gate per transaction. Weight/activation operands arrive LANES per beat over a valid/ready stream. A runtime mode selects a sigmoid gate (r/z) or a reset-gated tanh gate (n). It sits between the operand fetch/scheduler and the hidden-state update stage, and replaces full-vector-port gate elements in the GRU datapath.

## Interface
- D, 128: input vector length; must be a multiple of LANES (elaboration error otherwise)
- H, 256: hidden vector length; must be a multiple of LANES
- DATA_WIDTH, 16: signed fixed-point operand/result width
- FRAC_BITS, 8: fractional bits
- LANES, 4: multiply lanes per beat
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(D+H): accumulator width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  transaction request
- start_ready  out  1  high only in IDLE
- mode  in  1  0 = SIGMOID, 1 = TANH_RESET; sampled at start
- r_gate, b_i, b_h  in  DATA_WIDTH each  reset-gate value, input bias, hidden bias; sampled at start
- op_valid / op_ready  in / out  1  operand beat handshake
- op_w, op_a  in  LANES×DATA_WIDTH  weight and activation lanes
- op_last  in  1  marks the final hidden beat
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  DATA_WIDTH  gate value
- out_sat  out  1  saturation occurred in this transaction
- out_err  out  1  op_last protocol error in this transaction

## Operation
- States: IDLE → MAC_X (D/LANES beats) → MAC_H (H/LANES beats) → GATE → SUM → ACT → HOLD → IDLE.
- IDLE:
  - start handshake latches mode, r_gate, b_i, b_h.
  - Clears acc_x, acc_h, beat counter, sat and err.
- MAC_X / MAC_H:
  - op_ready = 1.
  - Each accepted beat adds the signed sum of LANES products op_w[i]*op_a[i] (full 2*DATA_WIDTH products, exact tree sum) to acc_x or acc_h.
  - Cycles with op_valid low stall the state machine with no change.
- op_last:
  - Expected only on beat D/LANES + H/LANES.
  - High earlier, or low on that beat: sets err. Beat counting still governs the state transition.
- GATE:
  - hid = sat(acc_h >>> FRAC_BITS) + b_h, narrowed to DATA_WIDTH.
  - TANH_RESET: g = narrow((r_gate * hid) >>> FRAC_BITS).
  - SIGMOID: g = hid.
- SUM: s = narrow(narrow(acc_x >>> FRAC_BITS) + b_i + g).
- ACT, with one = 1<<FRAC_BITS:
  - TANH_RESET: −one if s < −2·one; one if s > 2·one; else s >>> 1.
  - SIGMOID: clamp(one/2 + (s >>> 2), 0, one).
- HOLD:
  - out_valid = 1; out_data, out_sat and out_err stay stable until out_ready.
  - Handshake returns to IDLE on the next edge.
- Narrowing is defined under Configuration.

## Timing
- Reset values: start_ready = 0 during reset, 1 in the first cycle after reset release (IDLE). op_ready, out_valid, out_data, out_sat, out_err, accumulators and counter are all 0. State is IDLE.
- Zero-stall latency:
  - Start is accepted at edge E0.
  - The first operand beat can be accepted at E0+1.
  - If the last beat is accepted at edge E, out_valid is high after E+3.
  - Total = D/LANES + H/LANES + 4 edges from start to out_valid.
- Every op_valid bubble or out_ready-low cycle extends latency by one cycle.
- start_ready is low in every non-IDLE state. The earliest next start is one cycle after the output handshake.
- op_ready is 0 outside MAC_X/MAC_H. Beats presented then are ignored.
- rst asserted in any state: immediately returns to reset values. The in-flight transaction is discarded and no partial result is emitted.

## Configuration
- GRU_GATE_SAT_EN defined:
  - narrow() saturates to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Any clamp event sets sat, reported on out_sat.
- GRU_GATE_SAT_EN undefined:
  - narrow() keeps the low DATA_WIDTH bits (two's-complement wrap).
  - out_sat is tied 0.

## Structure
- Shared package gru_pkg:
  - gate_mode_t enum (SIGMOID, TANH_RESET).
  - gate_state_t enum.
  - narrow/saturate function.
  - tanh_pwl and sigmoid_hard functions, parametrised by DATA_WIDTH and FRAC_BITS.
- One sub-module: gru_lane_dot, a combinational LANES-wide signed multiply plus adder tree producing a 2*DATA_WIDTH+$clog2(LANES) sum.

## Test plan
Configuration for all scenarios: DATA_WIDTH=16, FRAC_BITS=8, D=4, H=4, LANES=2.
- TANH_RESET, x=256, w=64 (all lanes), h=0, biases 0, r=256 → out_data=128, out_sat=0, out_valid after exactly 8 edges from start.
- SIGMOID, all operands 0 → out_data=128. Then x=256, w=256 (sum 4.0) → out_data=256.
- TANH_RESET, x=0, h=256, w_h=192 (acc 3.0), r_gate=0 → out_data=0.
- w=x=0x7F00 on all lanes, macro defined → out_data=256, out_sat=1. Macro undefined → wrapped result matching the reference model, out_sat=0.
- op_valid toggled every other cycle plus out_ready held low 5 cycles → latency grows by the bubble count; out_data stable while held; start_ready=0 until handshake.
- op_last asserted on beat 2 → out_err=1. rst pulsed mid-MAC_H → out_valid stays 0, start_ready=1 after release, and the next transaction is correct.
